// File: rtl/waterlight_pkg.sv
// waterlight_pkg: shared encodings for the WaterLight step scheduler.
// Latency: n/a (constants only).
// Backpressure: n/a.
package waterlight_pkg;

  localparam int WL_MODE_W  = 8;
  localparam int WL_SPEED_W = 32;

  // Modes understood by the WaterLight LED block
  localparam logic [WL_MODE_W-1:0] WL_MODE_OFF   = 8'h00;
  localparam logic [WL_MODE_W-1:0] WL_MODE_LEFT  = 8'h01;
  localparam logic [WL_MODE_W-1:0] WL_MODE_RIGHT = 8'h02;
  localparam logic [WL_MODE_W-1:0] WL_MODE_FLASH = 8'h03;

  // Scheduler FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_PAUSED = 2'd3;

endpackage

// File: rtl/wl_step_table.sv
// wl_step_table: STEPS x (mode, speed, dwell) register file, one write port, one registered read port.
// Latency: read data appears the cycle after i_re; writes land on the next edge.
// Backpressure: none; the read register holds its value while i_re is low.
// Ports: clk/RST; i_we/i_waddr/i_wmode/i_wspeed/i_wdur write port;
//        i_re/i_raddr read request; o_rmode/o_rspeed/o_rdur registered read data.
module wl_step_table
  import waterlight_pkg::*;
#(
  parameter int STEPS = 8,
  parameter int AW    = 3,
  parameter int DUR_W = 16
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [WL_MODE_W-1:0]  i_wmode,
  input  logic [WL_SPEED_W-1:0] i_wspeed,
  input  logic [DUR_W-1:0]      i_wdur,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [WL_MODE_W-1:0]  o_rmode,
  output logic [WL_SPEED_W-1:0] o_rspeed,
  output logic [DUR_W-1:0]      o_rdur
);

  localparam int ENT_W = WL_MODE_W + WL_SPEED_W + DUR_W;

  logic [ENT_W-1:0] r_mem [STEPS];
  logic [ENT_W-1:0] r_rdat;

  // Table storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= {i_wmode, i_wspeed, i_wdur};
    end
  end

  // The read register only moves on request, so the current step's values
  // stay stable even if software rewrites that entry mid-step.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_rdat <= '0;
    end else if (i_re) begin
      r_rdat <= r_mem[i_raddr];
    end
  end

  assign {o_rmode, o_rspeed, o_rdur} = r_rdat;

endmodule

// File: rtl/waterlight_scheduler.sv
// waterlight_scheduler: steps the WaterLight block through a table of (mode, speed, dwell) entries.
// Latency: start -> new mode/speed two cycles later; each step costs one LOAD cycle plus its dwell.
// Backpressure: none; pause freezes dwell counting, stop aborts, start while busy is dropped.
// Ports: clk/RST; cfg_we/cfg_addr/cfg_mode/cfg_speed/cfg_dur table write; num_steps/loop_en
//        program shape; start/stop/pause control; WaterLight_mode/WaterLight_speed drive the LED
//        block; busy/step_idx/done status. Optional irq/irq_clr exist when WLSCHED_IRQ_EN is defined.
module waterlight_scheduler
  import waterlight_pkg::*;
#(
  parameter int STEPS = 8,
  parameter int AW    = 3,
  parameter int DUR_W = 16
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [WL_MODE_W-1:0]  cfg_mode,
  input  logic [WL_SPEED_W-1:0] cfg_speed,
  input  logic [DUR_W-1:0]      cfg_dur,
  input  logic [AW:0]           num_steps,
  input  logic                  loop_en,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  output logic [WL_MODE_W-1:0]  WaterLight_mode,
  output logic [WL_SPEED_W-1:0] WaterLight_speed,
  output logic                  busy,
  output logic [AW-1:0]         step_idx,
  output logic                  done
`ifdef WLSCHED_IRQ_EN
  ,
  output logic                  irq,
  input  logic                  irq_clr
`endif
);

  logic [1:0]            r_state;
  logic [AW-1:0]         r_step_idx;
  logic [AW:0]           r_num;
  logic                  r_loop;
  logic                  r_mode_on;
  logic                  r_done;
  logic [WL_SPEED_W-1:0] r_unit_cnt;
  logic [DUR_W-1:0]      r_dur_cnt;

  logic [WL_MODE_W-1:0]  w_cur_mode;
  logic [WL_SPEED_W-1:0] w_cur_speed;
  logic [DUR_W-1:0]      w_cur_dur;
  logic [DUR_W-1:0]      w_dur_last;
  logic                  w_read;
  logic                  w_unit_wrap;
  logic                  w_step_end;
  logic                  w_last_step;
  logic                  w_finish;

  // A stop during LOAD must not disturb the held speed, so the read is suppressed.
  assign w_read = (r_state == ST_LOAD) && !stop;

  wl_step_table #(
    .STEPS (STEPS),
    .AW    (AW),
    .DUR_W (DUR_W)
  ) u_table (
    .clk      (clk),
    .RST      (RST),
    .i_we     (cfg_we),
    .i_waddr  (cfg_addr),
    .i_wmode  (cfg_mode),
    .i_wspeed (cfg_speed),
    .i_wdur   (cfg_dur),
    .i_re     (w_read),
    .i_raddr  (r_step_idx),
    .o_rmode  (w_cur_mode),
    .o_rspeed (w_cur_speed),
    .o_rdur   (w_cur_dur)
  );

  // A zero dwell is treated as one unit.
  assign w_dur_last  = (w_cur_dur == '0) ? '0 : w_cur_dur - DUR_W'(1);
  assign w_unit_wrap = (r_unit_cnt == w_cur_speed);
  assign w_step_end  = w_unit_wrap && (r_dur_cnt == w_dur_last);
  assign w_last_step = ({1'b0, r_step_idx} == (r_num - (AW+1)'(1)));
  assign w_finish    = (r_state == ST_RUN) && !pause && !stop &&
                       w_step_end && w_last_step && !r_loop;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_step_idx <= '0;
      r_num      <= '0;
      r_loop     <= 1'b0;
      r_mode_on  <= 1'b0;
      r_done     <= 1'b0;
      r_unit_cnt <= '0;
      r_dur_cnt  <= '0;
    end else begin
      r_done <= w_finish;
      if (stop) begin
        // Also covers start+stop in IDLE: stop wins.
        r_state   <= ST_IDLE;
        r_mode_on <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && (num_steps != '0)) begin
              r_num      <= num_steps;
              r_loop     <= loop_en;
              r_step_idx <= '0;
              r_state    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            // Table data lands this edge; outputs switch to it from here on.
            r_unit_cnt <= '0;
            r_dur_cnt  <= '0;
            r_mode_on  <= 1'b1;
            r_state    <= ST_RUN;
          end
          ST_RUN: begin
            // The cycle that sees pause already counts as frozen.
            if (pause) begin
              r_state <= ST_PAUSED;
            end else if (!w_unit_wrap) begin
              r_unit_cnt <= r_unit_cnt + WL_SPEED_W'(1);
            end else begin
              r_unit_cnt <= '0;
              if (!w_step_end) begin
                r_dur_cnt <= r_dur_cnt + DUR_W'(1);
              end else if (!w_last_step) begin
                r_step_idx <= r_step_idx + AW'(1);
                r_state    <= ST_LOAD;
              end else if (r_loop) begin
                r_step_idx <= '0;
                r_state    <= ST_LOAD;
              end else begin
                r_state   <= ST_IDLE;
                r_mode_on <= 1'b0;
              end
            end
          end
          ST_PAUSED: begin
            if (!pause) begin
              r_state <= ST_RUN;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef WLSCHED_IRQ_EN
  logic r_irq;

  // Setting on both the finishing edge and the visible done cycle lets set win
  // over a clear landing on either of those cycles.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_irq <= 1'b0;
    end else if (w_finish || r_done) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

  // Speed keeps its last value when idle; only mode is forced off.
  assign WaterLight_mode  = r_mode_on ? w_cur_mode : WL_MODE_OFF;
  assign WaterLight_speed = w_cur_speed;
  assign busy             = (r_state != ST_IDLE);
  assign step_idx         = r_step_idx;
  assign done             = r_done;

endmodule
